// File: rtl/edge_rate_recovery.sv
// edge_rate_recovery
// Measures the high and low phase lengths of a synchronised incoming clock
// sample in system-clock cycles. It emits registered per-edge event pulses and
// tracks whether consecutive full periods agree within a tolerance.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   clk_en                clock enable; all state holds while low
//   recovery_en_i         measurement enable; low returns to idle with state cleared
//   clear_state_i         synchronous clear of measurement/lock state
//   io_clk_i              synchronised incoming clock sample
//   tolerance_i           max |new - previous| full period for a match
//   lock_threshold_i      consecutive matches needed to lock (0 acts as 1)
//   recovered_events_o    {fall, rise} single-cycle pulses
//   counter_current_o     cycles elapsed in current phase
//   high_rate_o/low_rate_o/full_rate_o   last measured phase lengths
//   fully_locked_in_o     high while locked
//   stall_violation_o     pulse when the phase counter saturates with no edge
module edge_rate_recovery #(
    parameter int unsigned RATE_COUNTER_WIDTH = 16,
    parameter int unsigned LOCK_COUNT_WIDTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clk_en,
    input  logic                          recovery_en_i,
    input  logic                          clear_state_i,
    input  logic                          io_clk_i,
    input  logic [RATE_COUNTER_WIDTH-1:0] tolerance_i,
    input  logic [LOCK_COUNT_WIDTH-1:0]   lock_threshold_i,
    output logic [1:0]                    recovered_events_o,
    output logic [RATE_COUNTER_WIDTH-1:0] counter_current_o,
    output logic [RATE_COUNTER_WIDTH-1:0] high_rate_o,
    output logic [RATE_COUNTER_WIDTH-1:0] low_rate_o,
    output logic [RATE_COUNTER_WIDTH-1:0] full_rate_o,
    output logic                          fully_locked_in_o,
    output logic                          stall_violation_o
);

    typedef logic [RATE_COUNTER_WIDTH-1:0] rate_t;
    typedef logic [LOCK_COUNT_WIDTH-1:0]   lock_t;
    typedef enum logic [1:0] {StIdle, StWaitFirst, StMeasure, StLocked} state_e;

    state_e state_q, state_d;
    logic   io_clk_q;
    rate_t  counter_q, counter_d;
    rate_t  high_q, high_d, low_q, low_d, full_q, full_d;
    logic [1:0] events_q, events_d;
    logic   stall_q, stall_d;
    lock_t  match_q, match_d;
    // partial: the phase in progress started in the wait state and is discarded.
    logic   partial_q, partial_d;
    // Validity of captured high phase / full period since the last restart.
    logic   high_valid_q, high_valid_d;
    logic   full_valid_q, full_valid_d;

    logic  rise, fall, edge_det, active, stall_hit, compare, match;
    rate_t len, new_full, diff;
    lock_t match_inc, thr_eff;

    assign rise     = io_clk_i & ~io_clk_q;
    assign fall     = ~io_clk_i & io_clk_q;
    assign edge_det = rise | fall;
    assign active   = (state_q == StMeasure) || (state_q == StLocked);

    assign len       = (counter_q == '1) ? counter_q : counter_q + 1'b1;
    assign new_full  = high_q + len;
    assign diff      = (new_full >= full_q) ? new_full - full_q : full_q - new_full;
    assign match     = diff <= tolerance_i;
    assign match_inc = (match_q == '1) ? match_q : match_q + 1'b1;
    assign thr_eff   = (lock_threshold_i == '0) ? lock_t'(1) : lock_threshold_i;

    assign stall_hit = active & ~edge_det & (counter_q == '1);
    // A period is only judged once both it and the previous one were fully observed.
    assign compare   = active & rise & ~partial_q & high_valid_q & full_valid_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:      if (recovery_en_i) state_d = StWaitFirst;
            StWaitFirst: if (edge_det) state_d = StMeasure;
            StMeasure: begin
                if (stall_hit) state_d = StWaitFirst;
                else if (compare && match && (match_inc >= thr_eff)) state_d = StLocked;
            end
            StLocked: begin
                if (stall_hit) state_d = StWaitFirst;
                else if (compare && !match) state_d = StMeasure;
            end
            default: state_d = StIdle;
        endcase
        if (clear_state_i || !recovery_en_i) state_d = StIdle;
    end

    // FSM outputs
    always_comb begin
        fully_locked_in_o = (state_q == StLocked);
    end

    // Datapath next state
    always_comb begin
        counter_d    = counter_q;
        high_d       = high_q;
        low_d        = low_q;
        full_d       = full_q;
        events_d     = 2'b00;
        stall_d      = 1'b0;
        match_d      = match_q;
        partial_d    = partial_q;
        high_valid_d = high_valid_q;
        full_valid_d = full_valid_q;
        if (clear_state_i || !recovery_en_i) begin
            counter_d    = '0;
            high_d       = '0;
            low_d        = '0;
            full_d       = '0;
            match_d      = '0;
            partial_d    = 1'b0;
            high_valid_d = 1'b0;
            full_valid_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: counter_d = '0;
                StWaitFirst: begin
                    counter_d = '0;
                    if (edge_det) begin
                        events_d  = {fall, rise};
                        partial_d = 1'b1;
                    end
                end
                StMeasure, StLocked: begin
                    if (edge_det) begin
                        events_d  = {fall, rise};
                        counter_d = '0;
                        if (partial_q) begin
                            partial_d = 1'b0;
                        end else if (fall) begin
                            high_d       = len;
                            high_valid_d = 1'b1;
                        end else begin
                            low_d        = len;
                            full_d       = new_full;
                            full_valid_d = high_valid_q;
                            if (compare) match_d = match ? match_inc : '0;
                        end
                    end else if (stall_hit) begin
                        // Rates stay visible; everything else restarts from the first edge.
                        stall_d      = 1'b1;
                        match_d      = '0;
                        counter_d    = '0;
                        high_valid_d = 1'b0;
                        full_valid_d = 1'b0;
                    end else begin
                        counter_d = counter_q + 1'b1;
                    end
                end
                default: counter_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_clk_q     <= 1'b0;
            counter_q    <= '0;
            high_q       <= '0;
            low_q        <= '0;
            full_q       <= '0;
            events_q     <= 2'b00;
            stall_q      <= 1'b0;
            match_q      <= '0;
            partial_q    <= 1'b0;
            high_valid_q <= 1'b0;
            full_valid_q <= 1'b0;
        end else if (clk_en) begin
            io_clk_q     <= io_clk_i;
            counter_q    <= counter_d;
            high_q       <= high_d;
            low_q        <= low_d;
            full_q       <= full_d;
            events_q     <= events_d;
            stall_q      <= stall_d;
            match_q      <= match_d;
            partial_q    <= partial_d;
            high_valid_q <= high_valid_d;
            full_valid_q <= full_valid_d;
        end
    end

    assign recovered_events_o = events_q;
    assign counter_current_o  = counter_q;
    assign high_rate_o        = high_q;
    assign low_rate_o         = low_q;
    assign full_rate_o        = full_q;
    assign stall_violation_o  = stall_q;

endmodule

// File: tb/tb_edge_rate_recovery.sv
// Directed bench for edge_rate_recovery with an 8-bit rate counter.
module tb_edge_rate_recovery;

    localparam int unsigned W = 8;
    localparam int unsigned L = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clk_en;
    logic         recovery_en_i;
    logic         clear_state_i;
    logic         io_clk_i;
    logic [W-1:0] tolerance_i;
    logic [L-1:0] lock_threshold_i;
    logic [1:0]   recovered_events_o;
    logic [W-1:0] counter_current_o;
    logic [W-1:0] high_rate_o;
    logic [W-1:0] low_rate_o;
    logic [W-1:0] full_rate_o;
    logic         fully_locked_in_o;
    logic         stall_violation_o;

    edge_rate_recovery #(
        .RATE_COUNTER_WIDTH(W),
        .LOCK_COUNT_WIDTH  (L)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .clk_en            (clk_en),
        .recovery_en_i     (recovery_en_i),
        .clear_state_i     (clear_state_i),
        .io_clk_i          (io_clk_i),
        .tolerance_i       (tolerance_i),
        .lock_threshold_i  (lock_threshold_i),
        .recovered_events_o(recovered_events_o),
        .counter_current_o (counter_current_o),
        .high_rate_o       (high_rate_o),
        .low_rate_o        (low_rate_o),
        .full_rate_o       (full_rate_o),
        .fully_locked_in_o (fully_locked_in_o),
        .stall_violation_o (stall_violation_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Snapshots taken during a phase: after its first and second clock edge.
    logic [1:0]   ev1, ev2;
    logic [W-1:0] hi1, lo1, fu1, cnt256;
    logic         lk1;
    int           stall_cnt, stall_tick;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold io_clk_i at lvl for n sampling edges.
    task automatic phase(input logic lvl, input int n);
        io_clk_i = lvl;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (i == 1) begin
                ev1 = recovered_events_o;
                hi1 = high_rate_o;
                lo1 = low_rate_o;
                fu1 = full_rate_o;
                lk1 = fully_locked_in_o;
            end
            if (i == 2) ev2 = recovered_events_o;
            if (i == 256) cnt256 = counter_current_o;
            if (stall_violation_o) begin
                stall_cnt++;
                if (stall_tick == 0) stall_tick = i;
            end
        end
    endtask

    // Low phase of lo cycles then high phase of 4; snapshots describe the rise.
    task automatic period(input int lo);
        phase(1'b0, lo);
        phase(1'b1, 4);
    endtask

    initial begin
        rst_n            = 1'b0;
        clk_en           = 1'b1;
        recovery_en_i    = 1'b1;
        clear_state_i    = 1'b0;
        io_clk_i         = 1'b0;
        tolerance_i      = '0;
        lock_threshold_i = 4'd3;
        stall_cnt        = 0;
        stall_tick       = 0;
        tick();
        tick();
        check_eq("reset_events", recovered_events_o, 0);
        check_eq("reset_full", full_rate_o, 0);
        check_eq("reset_lock", fully_locked_in_o, 0);
        check_eq("reset_stall", stall_violation_o, 0);
        rst_n = 1'b1;
        tick();

        // Steady 4 high / 6 low.
        phase(1'b1, 4);
        check_eq("first_edge_rise", ev1, 2'b01);
        check_eq("pulse_one_cycle", ev2, 2'b00);
        phase(1'b0, 6);
        check_eq("fall_event", ev1, 2'b10);
        check_eq("partial_discard", hi1, 0);
        phase(1'b1, 4);
        check_eq("r1_low", lo1, 6);
        check_eq("r1_full", fu1, 6);
        phase(1'b0, 6);
        check_eq("f1_high", hi1, 4);
        phase(1'b1, 4);
        check_eq("r2_full", fu1, 10);
        check_eq("r2_unlocked", lk1, 0);
        period(6);
        check_eq("r3_unlocked", lk1, 0);
        period(6);
        check_eq("r4_unlocked", lk1, 0);
        period(6);
        check_eq("r5_locked", lk1, 1);
        check_eq("steady_high", hi1, 4);
        check_eq("steady_low", lo1, 6);
        check_eq("steady_full", fu1, 10);

        // Jitter within tolerance 1, then an out-of-range period.
        tolerance_i = 8'd1;
        period(7);
        check_eq("jit11_lock", lk1, 1);
        period(6);
        check_eq("jit10_lock", lk1, 1);
        period(7);
        check_eq("jit11b_lock", lk1, 1);
        period(9);
        check_eq("jump_full", fu1, 13);
        check_eq("jump_unlock", lk1, 0);
        period(9);
        period(9);
        check_eq("relock_2nd", lk1, 0);
        period(9);
        check_eq("relock_3rd", lk1, 1);

        // Stall: low for 300 cycles.
        phase(1'b0, 300);
        check_eq("stall_cnt255", cnt256, 255);
        check_eq("stall_pulses", stall_cnt, 1);
        check_eq("stall_tick", stall_tick, 257);
        check_eq("stall_unlock", fully_locked_in_o, 0);
        check_eq("stall_high_kept", high_rate_o, 4);
        check_eq("stall_full_kept", full_rate_o, 13);
        check_eq("stall_cnt_held", counter_current_o, 0);
        phase(1'b1, 5);
        check_eq("stall_first_rise", ev1, 2'b01);
        phase(1'b0, 6);
        check_eq("stall_discard", hi1, 4);
        phase(1'b1, 5);
        check_eq("stall_low", lo1, 6);
        check_eq("stall_full", fu1, 10);

        // Clear beats a same-cycle rise.
        phase(1'b0, 3);
        io_clk_i      = 1'b1;
        clear_state_i = 1'b1;
        tick();
        clear_state_i = 1'b0;
        check_eq("clear_no_event", recovered_events_o, 0);
        check_eq("clear_high", high_rate_o, 0);
        check_eq("clear_full", full_rate_o, 0);
        check_eq("clear_cnt", counter_current_o, 0);
        tick();

        // Clock-enable freeze.
        phase(1'b0, 3);
        check_eq("cnt_before_freeze", counter_current_o, 2);
        clk_en = 1'b0;
        repeat (5) tick();
        check_eq("cnt_frozen", counter_current_o, 2);
        clk_en = 1'b1;
        tick();
        check_eq("cnt_resumed", counter_current_o, 3);

        // Threshold 0 acts as 1.
        lock_threshold_i = '0;
        phase(1'b1, 4);
        check_eq("clr_discard_ev", ev1, 2'b01);
        check_eq("clr_discard_low", lo1, 0);
        phase(1'b0, 6);
        phase(1'b1, 4);
        check_eq("thr0_first_full", lk1, 0);
        period(6);
        check_eq("thr0_lock", lk1, 1);

        // Disable while locked.
        recovery_en_i = 1'b0;
        tick();
        check_eq("dis_unlock", fully_locked_in_o, 0);
        check_eq("dis_cnt", counter_current_o, 0);
        check_eq("dis_high", high_rate_o, 0);
        recovery_en_i = 1'b1;
        tick();
        phase(1'b0, 6);
        check_eq("reen_first_fall", ev1, 2'b10);
        phase(1'b1, 4);
        check_eq("reen_discard", lo1, 0);
        phase(1'b0, 6);
        check_eq("reen_high", hi1, 4);

        // Asynchronous reset between clock edges.
        check_eq("pre_areset_cnt", counter_current_o, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("areset_cnt", counter_current_o, 0);
        check_eq("areset_high", high_rate_o, 0);
        check_eq("areset_events", recovered_events_o, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_rate_recovery.md
Name: edge_rate_recovery

Overview:
Recovers the timing of an incoming, already-synchronised I/O clock sample by measuring high and low phase lengths in system-clock cycles. Emits per-edge event pulses, the current phase counter, high/low/full rate measurements and a lock indication. Sits directly upstream of clock_generation and drives its recovered_events_i, fully_locked_in_i, high_rate_i, low_rate_i, full_rate_i and counter_current_i inputs.

Parameters:
RATE_COUNTER_WIDTH, 16, width of phase counter and rate outputs (matches clks_alot_p::RATE_COUNTER_WIDTH)
LOCK_COUNT_WIDTH, 4, width of the consecutive-match counter and lock_threshold_i

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clk_en  in  1  clock enable; all state holds when low
recovery_en_i  in  1  enables measurement; low forces IDLE
clear_state_i  in  1  synchronous clear of all measurement/lock state
io_clk_i  in  1  synchronised incoming clock sample
tolerance_i  in  RATE_COUNTER_WIDTH  max allowed |new - previous| for a phase to count as matching
lock_threshold_i  in  LOCK_COUNT_WIDTH  consecutive matching full periods required to lock; 0 treated as 1
recovered_events_o  out  2  {falling_edge, rising_edge} single-cycle pulses (clks_alot_p::recovered_events_s)
counter_current_o  out  RATE_COUNTER_WIDTH  cycles elapsed in current phase
high_rate_o  out  RATE_COUNTER_WIDTH  last measured high-phase length
low_rate_o  out  RATE_COUNTER_WIDTH  last measured low-phase length
full_rate_o  out  RATE_COUNTER_WIDTH  high_rate + low_rate, truncated to width
fully_locked_in_o  out  1  measurements stable for lock_threshold_i periods
stall_violation_o  out  1  single-cycle pulse: phase counter saturated with no edge

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, io_clk_q = 0, state IDLE, match count 0.
- All register updates are qualified by clk_en. clear_state_i (when clk_en is high) has the same effect as reset, except io_clk_q loads io_clk_i. clear_state_i wins over any same-cycle edge.
- Edge detect: io_clk_q <= io_clk_i every enabled cycle.
  - rise = io_clk_i & ~io_clk_q.
  - fall = ~io_clk_i & io_clk_q.
- States:
  - IDLE: counters are 0. Moves to WAIT_FIRST_EDGE when recovery_en_i is high.
  - WAIT_FIRST_EDGE: phase counter held at 0. No rate capture. On the first rise or fall, emit the event pulse, start counting, and go to MEASURE.
  - MEASURE: normal counting and capture. Go to LOCKED when the match count reaches max(lock_threshold_i, 1).
  - LOCKED: same datapath as MEASURE. fully_locked_in_o = 1 only in LOCKED.
  - Any state: recovery_en_i low -> IDLE next cycle, with outputs cleared as for reset.
- Phase counter (MEASURE/LOCKED):
  - On a detected edge, len = counter + 1 and counter <= 0.
  - Otherwise counter <= counter + 1, saturating at all-ones.
  - counter_current_o is the registered counter.
- Capture:
  - A fall ends a high phase: high_rate_o <= len.
  - A rise ends a low phase: low_rate_o <= len, and full_rate_o <= high_rate_o + len.
  - The first phase after WAIT_FIRST_EDGE is partial, so the first capture is discarded (its rate output is not written).
- Event latency: recovered_events_o pulses for one cycle, registered in the cycle after detection. The captured rates are visible in the same cycle as the pulse.
- Match logic:
  - Evaluated on each rise with both phases valid: new full length compared against the previous full_rate_o.
  - Match when the absolute difference is <= tolerance_i.
  - A match increments the match count (saturating); a mismatch clears it to 0.
  - A mismatch in LOCKED drops to MEASURE; fully_locked_in_o falls in the same cycle as the event pulse.
- Stall: if the counter reaches all-ones with no edge:
  - stall_violation_o pulses once;
  - match count is cleared and the state goes to WAIT_FIRST_EDGE;
  - rate outputs are retained.
- A rise and a fall cannot both occur in one cycle (single-bit input).

Test Plan:
- Reset values: assert rst_n low mid-MEASURE -> all outputs 0 immediately (asynchronously). After release with recovery_en_i=1, state goes IDLE -> WAIT_FIRST_EDGE.
- Steady clock: io_clk_i high 4 / low 6 cycles, tolerance 0, threshold 3 -> high_rate_o=4, low_rate_o=6, full_rate_o=10. fully_locked_in_o rises on the 3rd matching rise event after the first full period. Event pulses occur 1 cycle after each io_clk_i transition.
- Jitter: after lock, tolerance 1, alternate periods of 10 and 11 -> stays locked. Then one period of 13 -> lock drops on that rise and re-locks after 3 more matching periods.
- Stall: RATE_COUNTER_WIDTH=8, hold io_clk_i low for 300 cycles -> stall_violation_o pulses once when the counter reaches 255, lock clears, rates are retained, and the state waits for the first edge.
- Control precedence: assert clear_state_i in the same cycle as a rise -> no event pulse and all outputs 0. Hold clk_en=0 for 5 cycles mid-phase -> counter_current_o is frozen.
- Disable: drop recovery_en_i while LOCKED -> the next cycle shows fully_locked_in_o=0 and counters 0. Re-enabling discards the first partial phase.
